seg_scan_display: RTL and testbench
===================================

# seg_scan_display

Downstream display stage for the stopwatch/countdown timer. Takes the four binary time fields (hours, minutes, seconds, centiseconds, each 0-99) and drives an 8-digit multiplexed 7-segment display. The block performs the following, all in one scan-clock domain:
- frame-synchronous snapshotting of the inputs, so the display never tears;
- sequential binary-to-BCD conversion;
- digit scanning;
- decimal-point insertion;
- field blinking for the countdown setting mode.

## Interface
- `DWELL`, default 10: scan-clock cycles each digit stays enabled. Legal range is DWELL ≥ 5.
- `BLINK_FRAMES`, default 31: frames per blink half-period.
- `DP_MASK`, default 8'b0101_0100: digit positions whose decimal point is lit.

- `clk_10khz`  in  1  scan clock; the only clock.
- `rst`  in  1  reset. Asynchronous, active-high.
- `hour`  in  8  binary hours, nominal range 0-99.
- `min`  in  8  binary minutes, nominal range 0-59.
- `sec`  in  8  binary seconds, nominal range 0-59.
- `centisec`  in  8  binary centiseconds, nominal range 0-99.
- `blink_hour`  in  1  when high, the hour digits blink.
- `blink_min`  in  1  when high, the minute digits blink.
- `seg`  out  8  segment drive, active-high. Bit 0 = a … bit 6 = g, bit 7 = dp.
- `an`  out  8  digit enable, active-high, one-hot.

## Operation
- **Digit map (an index):**
  - 7 = hour tens, 6 = hour ones
  - 5 = min tens, 4 = min ones
  - 3 = sec tens, 2 = sec ones
  - 1 = centisec tens, 0 = centisec ones
- **Scan:**
  - A dwell counter counts 0..DWELL-1.
  - The digit index advances on dwell wrap: 0→1→…→7→0.
  - A frame is 8×DWELL cycles.
- **Frame start:** the cycle in which the index wraps 7→0, plus the first cycle after reset release. At frame start, three things happen in the same cycle:
  1. The pending BCD result is copied into the display registers.
  2. `hour`, `min`, `sec`, `centisec`, `blink_hour` and `blink_min` are latched.
  3. The converter is started.
- **Converter FSM:** states are IDLE → CONV → DONE → IDLE.
  - CONV runs a shift-add-3 (double dabble) conversion, 8 iterations per field, fields in the order centisec, sec, min, hour. CONV therefore lasts 32 cycles.
  - DONE writes all four results into the pending registers atomically, then returns to IDLE.
  - Total conversion takes 34 cycles, which is less than one frame for every legal DWELL.
  - A frame start is never seen outside IDLE.
- **Over-range:** a latched field value > 99 is flagged. Both digits of that field show a dash (seg = 8'h40, dp off) instead of digits.
- **Decode:**
  - Standard 0-9 patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Leading zeros are always shown; there is no blanking.
  - Bit 7 = DP_MASK[index], except for dash or blanked digits, where dp is off.
- **Blink:**
  - A frame counter toggles `blink_phase` every BLINK_FRAMES frames.
  - When the latched blink_x = 1 and `blink_phase` = off, the field's two digits output seg = 8'h00. `an` still scans.
  - When the latched blink_x = 0, the field is always visible.
  - `blink_phase` is held at "on" and the frame counter is held cleared while both blink inputs are latched low. Blinking therefore always starts visible.
- **Reset (async, any time, including mid-CONV):**
  - `seg` = 8'h00 and `an` = 8'h00 immediately.
  - Index, dwell counter, frame counter and converter are cleared; the FSM goes to IDLE.
  - Pending and display registers are cleared to all-zero BCD.
  - `blink_phase` is set to on.

## Timing
- Outputs are registered.
- On the first `clk_10khz` edge after `rst` falls:
  - `an` = 8'h01.
  - `seg` = 8'h3F, from the zeroed display registers.
  - This cycle is frame start 0.
- Each `an` value persists exactly DWELL cycles. With DWELL=10 and a 10 kHz clock, the frame is 8 ms (125 Hz refresh).
- Latency: inputs latched at frame start k appear on `seg` from frame start k+1, which is exactly 8×DWELL cycles later.
- Inputs are sampled only at frame start. Changes between frame starts are ignored until the next frame start.
- The display registers change only at frame start, so there is no intra-frame tearing.
- Blink half-period = BLINK_FRAMES × 8 × DWELL cycles. Defaults give 2480 cycles = 248 ms.

## Test plan
- **Reset release:** hold rst, then release with all inputs 0 → first edge gives an=01, seg=3F. `an` walks 01,02,04,…,80, each for 10 cycles. Digits 2, 4 and 6 show seg=BF.
- **Value latency:** hour=12, min=34, sec=56, centisec=78 applied before frame start k.
  - Frame k+1 shows, for an index 7..0: 06, CF(4+dp)… Exact values: 7:5B? No — 7:"1"=06, 6:"2"+dp=DB, 5:"3"=4F, 4:"4"+dp=E6, 3:"5"=6D, 2:"6"+dp=FD, 1:"7"=07, 0:"8"=7F.
  - Frame k still shows zeros.
- **No tearing:** change sec from 56 to 57 mid-frame → the whole current frame shows 56; 57 appears only from the next frame start.
- **Over-range:** min=150 → an indices 5 and 4 show seg=40; the other fields are decoded normally.
- **Blink:** blink_min=1 from frame start F → min digits visible for frames F+1..F+31, then seg=00 on indices 5/4 for the next 31 frames, and so on. Deassert → visible from the next frame start.
- **Mid-conversion reset:** assert rst 10 cycles into CONV → outputs are 00 asynchronously. After release, the display shows all zeros for the first frame, with no stale partial result.

Source files
------------

// File: rtl/seg_scan_display.sv
`timescale 1ns/1ps
// Display stage for the stopwatch/countdown timer: snapshots the time fields once per
// frame, converts them to BCD serially and scans an 8-digit multiplexed 7-segment display.
//   state | meaning
//   IDLE  | waiting for a frame start
//   CONV  | double dabble, 8 steps per field, centisec -> sec -> min -> hour
//   DONE  | publish all four results to the pending registers at once
module seg_scan_display #(
   parameter int         DWELL        = 10,
   parameter int         BLINK_FRAMES = 31,
   parameter logic [7:0] DP_MASK      = 8'b0101_0100
) (
   input  logic       clk_10khz,
   input  logic       rst,
   input  logic [7:0] hour,
   input  logic [7:0] min,
   input  logic [7:0] sec,
   input  logic [7:0] centisec,
   input  logic       blink_hour,
   input  logic       blink_min,
   output logic [7:0] seg,
   output logic [7:0] an
);

   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int BW = $clog2(BLINK_FRAMES + 1);

   typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_t;

   conv_state_t       state, state_n;
   logic              started;
   logic [2:0]        idx, idx_n;
   logic [DW-1:0]     dwell, dwell_n;
   logic              fs;

   logic [3:0][7:0]   snap;
   logic [1:0]        blink_lat, blink_disp, blink_disp_n;
   logic [3:0][7:0]   res_bcd, pend_bcd, disp_bcd, disp_bcd_n;
   logic [3:0]        pend_ovr, disp_ovr, disp_ovr_n;
   logic              phase, phase_n;
   logic [BW-1:0]     fcnt, fcnt_n;

   logic [1:0]        fld;
   logic [2:0]        bit_cnt;
   logic [15:0]       sreg, dd_adj, dd_shift;

   logic [1:0]        fld_o;
   logic [3:0]        digit;
   logic              blank;
   logic [6:0]        pat;
   logic [7:0]        seg_n, an_n;

   // Scan position and frame-start detection
   always_comb begin
      idx_n   = idx;
      dwell_n = dwell;
      fs      = 1'b0;
      if (!started) begin
         fs = 1'b1;
      end else if (dwell == DW'(DWELL - 1)) begin
         dwell_n = '0;
         idx_n   = idx + 3'd1;
         fs      = (idx == 3'd7);
      end else begin
         dwell_n = dwell + 1'b1;
      end
   end

   // Frame-level state; blink masks travel with the data they were latched alongside
   always_comb begin
      disp_bcd_n   = disp_bcd;
      disp_ovr_n   = disp_ovr;
      blink_disp_n = blink_disp;
      phase_n      = phase;
      fcnt_n       = fcnt;
      if (fs) begin
         disp_bcd_n   = pend_bcd;
         disp_ovr_n   = pend_ovr;
         blink_disp_n = blink_lat;
         if ({blink_hour, blink_min} == 2'b00) begin
            phase_n = 1'b1;
            fcnt_n  = '0;
         end else if (blink_disp != 2'b00) begin
            if (fcnt == BW'(BLINK_FRAMES - 1)) begin
               phase_n = ~phase;
               fcnt_n  = '0;
            end else begin
               fcnt_n = fcnt + 1'b1;
            end
         end
      end
   end

   // Outputs are built from next-cycle values so a frame shows new data from its first cycle
   always_comb begin
      fld_o = idx_n[2:1];
      digit = idx_n[0] ? disp_bcd_n[fld_o][7:4] : disp_bcd_n[fld_o][3:0];
      blank = !phase_n && ((fld_o == 2'd3 && blink_disp_n[1]) ||
                           (fld_o == 2'd2 && blink_disp_n[0]));
      case (digit)
         4'd0:    pat = 7'h3F;
         4'd1:    pat = 7'h06;
         4'd2:    pat = 7'h5B;
         4'd3:    pat = 7'h4F;
         4'd4:    pat = 7'h66;
         4'd5:    pat = 7'h6D;
         4'd6:    pat = 7'h7D;
         4'd7:    pat = 7'h07;
         4'd8:    pat = 7'h7F;
         4'd9:    pat = 7'h6F;
         default: pat = 7'h00;
      endcase
      if (blank)
         seg_n = 8'h00;
      else if (disp_ovr_n[fld_o])
         seg_n = 8'h40;
      else
         seg_n = {DP_MASK[idx_n], pat};
      an_n = 8'h01 << idx_n;
   end

   always_ff @(posedge clk_10khz or posedge rst) begin
      if (rst) begin
         started    <= 1'b0;
         idx        <= '0;
         dwell      <= '0;
         snap       <= '0;
         blink_lat  <= '0;
         blink_disp <= '0;
         disp_bcd   <= '0;
         disp_ovr   <= '0;
         phase      <= 1'b1;
         fcnt       <= '0;
         seg        <= 8'h00;
         an         <= 8'h00;
      end else begin
         started    <= 1'b1;
         idx        <= idx_n;
         dwell      <= dwell_n;
         blink_disp <= blink_disp_n;
         disp_bcd   <= disp_bcd_n;
         disp_ovr   <= disp_ovr_n;
         phase      <= phase_n;
         fcnt       <= fcnt_n;
         seg        <= seg_n;
         an         <= an_n;
         if (fs) begin
            snap      <= {hour, min, sec, centisec};
            blink_lat <= {blink_hour, blink_min};
         end
      end
   end

   // One double dabble step; only two BCD digits are kept since values above 99 show a dash
   always_comb begin
      dd_adj = sreg;
      if (sreg[11:8] >= 4'd5)
         dd_adj[11:8] = sreg[11:8] + 4'd3;
      if (sreg[15:12] >= 4'd5)
         dd_adj[15:12] = sreg[15:12] + 4'd3;
      dd_shift = {dd_adj[14:0], 1'b0};
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (fs) state_n = CONV;
         CONV:    if (fld == 2'd3 && bit_cnt == 3'd7) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_10khz or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_ff @(posedge clk_10khz or posedge rst) begin
      if (rst) begin
         sreg     <= '0;
         fld      <= '0;
         bit_cnt  <= '0;
         res_bcd  <= '0;
         pend_bcd <= '0;
         pend_ovr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (fs) begin
                  sreg    <= {8'h00, centisec};
                  fld     <= '0;
                  bit_cnt <= '0;
               end
            end
            CONV: begin
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  res_bcd[fld] <= dd_shift[15:8];
                  fld          <= fld + 2'd1;
                  sreg         <= {8'h00, snap[fld + 2'd1]};
               end else begin
                  sreg <= dd_shift;
               end
            end
            DONE: begin
               pend_bcd <= res_bcd;
               for (int i = 0; i < 4; i++)
                  pend_ovr[i] <= (snap[i] > 8'd99);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seg_scan_display.sv
`timescale 1ns/1ps
// Scoreboard bench for seg_scan_display: stimulus queues the expected an/seg for each
// digit slot, a monitor compares every cycle of those slots against the outputs.
module tb_seg_scan_display;

   localparam int DWELL = 10;

   logic       clk_10khz = 1'b0;
   logic       rst;
   logic [7:0] hour, min, sec, centisec;
   logic       blink_hour, blink_min;
   logic [7:0] seg, an;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc;

   typedef struct {
      int         slot;
      logic [7:0] an;
      logic [7:0] seg;
   } exp_t;

   exp_t q[$];

   // Frame images, byte i = seg for an index i
   localparam logic [63:0] F_ZERO  = 64'h3F_BF_3F_BF_3F_BF_3F_3F;
   localparam logic [63:0] F_V56   = 64'h06_DB_4F_E6_6D_FD_07_7F;
   localparam logic [63:0] F_V57   = 64'h06_DB_4F_E6_6D_87_07_7F;
   localparam logic [63:0] F_OVR   = 64'h06_DB_40_40_6D_87_07_7F;
   localparam logic [63:0] F_BLANK = 64'h06_DB_00_00_6D_87_07_7F;

   seg_scan_display #(.DWELL(DWELL), .BLINK_FRAMES(31), .DP_MASK(8'b0101_0100)) dut (
      .clk_10khz  (clk_10khz),
      .rst        (rst),
      .hour       (hour),
      .min        (min),
      .sec        (sec),
      .centisec   (centisec),
      .blink_hour (blink_hour),
      .blink_min  (blink_min),
      .seg        (seg),
      .an         (an)
   );

   always #5 clk_10khz = ~clk_10khz;

   always @(posedge clk_10khz or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, got, want, cyc);
      end
   endtask

   task automatic push_frame(input int f, input logic [63:0] segs);
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         e.slot = f * 8 + i;
         e.an   = 8'h01 << i;
         e.seg  = segs[8*i +: 8];
         q.push_back(e);
      end
   endtask

   task automatic wait_cyc(input int c);
      int guard;
      guard = 0;
      while (cyc < c && guard < 20000) begin
         @(negedge clk_10khz);
         guard++;
      end
      if (cyc < c) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_cyc: reached %0d expected %0d", cyc, c);
      end
   endtask

   // Monitor: every cycle of a queued slot is compared; the entry retires at slot end
   always @(negedge clk_10khz) begin
      if (!rst && cyc > 0 && q.size() > 0) begin
         if (q[0].slot < (cyc - 1) / DWELL) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missed_slot: slot %0d at cyc %0d", q[0].slot, cyc);
            void'(q.pop_front());
         end else if (q[0].slot == (cyc - 1) / DWELL) begin
            check($sformatf("an slot %0d", q[0].slot), {24'h0, an}, {24'h0, q[0].an});
            check($sformatf("seg slot %0d", q[0].slot), {24'h0, seg}, {24'h0, q[0].seg});
            if ((cyc - 1) % DWELL == DWELL - 1)
               void'(q.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      hour = 8'd0; min = 8'd0; sec = 8'd0; centisec = 8'd0;
      blink_hour = 1'b0; blink_min = 1'b0;
      repeat (3) @(negedge clk_10khz);
      check("reset an", {24'h0, an}, 32'h0);
      check("reset seg", {24'h0, seg}, 32'h0);

      // Frames 0..2 show zeros: frame 2 was latched at frame start 1 before the change at 85
      push_frame(0, F_ZERO);
      push_frame(1, F_ZERO);
      push_frame(2, F_ZERO);
      rst = 1'b0;

      wait_cyc(85);
      hour = 8'd12; min = 8'd34; sec = 8'd56; centisec = 8'd78;
      push_frame(3, F_V56);
      push_frame(4, F_V56);
      push_frame(5, F_V56);

      // Mid-frame change: frame 4 and 5 stay at 56, 57 shows from frame 6
      wait_cyc(360);
      sec = 8'd57;
      push_frame(6, F_V57);
      push_frame(7, F_V57);

      wait_cyc(485);
      min = 8'd150;
      push_frame(8, F_OVR);

      // Blink latched at frame start 9: visible 10..40, blanked 41..71
      wait_cyc(645);
      min = 8'd34;
      blink_min = 1'b1;
      push_frame(9, F_OVR);
      push_frame(10, F_V57);
      push_frame(40, F_V57);
      push_frame(41, F_BLANK);
      push_frame(45, F_BLANK);

      wait_cyc(45 * 80 + 5);
      blink_min = 1'b0;
      push_frame(46, F_V57);
      push_frame(47, F_V57);

      // Reset ten cycles into the conversion started at frame start 48
      wait_cyc(48 * 80 + 11);
      check("queue drained before reset", q.size(), 32'd0);
      #1 rst = 1'b1;
      #1;
      check("async reset an", {24'h0, an}, 32'h0);
      check("async reset seg", {24'h0, seg}, 32'h0);
      repeat (3) @(negedge clk_10khz);
      check("held reset an", {24'h0, an}, 32'h0);
      push_frame(0, F_ZERO);
      push_frame(1, F_V57);
      rst = 1'b0;

      wait_cyc(165);
      check("queue drained at end", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
